// File: rtl/f3m_digit_mult_if.sv
// Operand/result bundle for the GF(3^97) digit-serial multiplier.
// Trit i of each element lives in bits [2i+1:2i]; 2'b11 never appears on a legal value.
interface f3m_digit_mult_if;
    logic [193:0] a;
    logic [193:0] b;
    logic [193:0] c;
    logic         done;

    modport master (output a, output b, input  c, input  done);
    modport slave  (input  a, input  b, output c, output done);
endinterface

// File: rtl/f3m_digit_mult.sv
// GF(3^97) multiplier, f(x) = x^97 + x^12 + 2: one trit of b per clock, MSB first (Horner),
// reducing on the fly. A reset edge loads operands and restarts; done rises after 97 steps.
module f3m_digit_mult (
    input  logic               clk,
    input  logic               reset,
    f3m_digit_mult_if.slave    bus
);
    localparam int unsigned M   = 97;
    localparam int unsigned W   = 2 * M;
    localparam int unsigned CW  = 7;
    localparam int unsigned RED = 12;

    logic [W-1:0]  ra_q, rb_q, rb_d, acc_q, acc_d;
    logic [W-1:0]  shifted, addend;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [1:0]    t, d;

    // Carry-free mod-3 add of two encoded trits
    function automatic logic [1:0] tadd(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = 3'(x) + 3'(y);
        case (s)
            3'd1, 3'd4: tadd = 2'b01;
            3'd2:       tadd = 2'b10;
            default:    tadd = 2'b00;
        endcase
    endfunction

    // Negation swaps the 1 and 2 encodings; 0 stays 0
    function automatic logic [1:0] tneg(input logic [1:0] x);
        tneg = {x[0], x[1]};
    endfunction

    always_comb begin
        rb_d    = rb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        addend  = '0;
        t       = acc_q[W-1 -: 2];
        d       = rb_q[W-1 -: 2];

        // acc * x, folding the outgoing trit back in via x^97 = 2x^12 + 1
        shifted              = {acc_q[W-3:0], 2'b00};
        shifted[1:0]         = t;
        shifted[2*RED +: 2]  = tadd(shifted[2*RED +: 2], tneg(t));

        for (int unsigned i = 0; i < M; i++) begin
            case (d)
                2'b01:   addend[2*i +: 2] = ra_q[2*i +: 2];
                2'b10:   addend[2*i +: 2] = tneg(ra_q[2*i +: 2]);
                default: addend[2*i +: 2] = 2'b00;
            endcase
        end

        if (cnt_q < CW'(M)) begin
            for (int unsigned i = 0; i < M; i++) begin
                acc_d[2*i +: 2] = tadd(shifted[2*i +: 2], addend[2*i +: 2]);
            end
            rb_d   = {rb_q[W-3:0], 2'b00};
            cnt_d  = cnt_q + CW'(1);
            done_d = (cnt_q == CW'(M - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra_q   <= bus.a;
            rb_q   <= bus.b;
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rb_q   <= rb_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.c    = acc_q;
    assign bus.done = done_q;
endmodule
